// File: rtl/regfile_wb_arbiter.sv
// Purpose : shares the single register-file write port among NREQ writeback sources, round-robin.
// Latency : 1 cycle from a granted transfer (req_valid & req_ready) to the rf_* write.
// Backpress: the rf port never stalls, so some valid requester is granted every cycle; the rest wait.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot or zero
//   req_wa/req_wd       packed per-requester dest register (5b) and data (32b)
//   rf_we/rf_wa/rf_wd   registered register-file write port; rf_gid = source id
//   stat_grants         per-requester saturating grant counters (16b each)
//   stat_conflict       saturating count of cycles with two or more valid requesters
// Optional feature: define WB_STATS_EN to build the statistics counters;
// without it the stat_* outputs are constant zero and the port list is unchanged.
module regfile_wb_arbiter #(
  parameter int NREQ    = 3,
  parameter int REQ_IDW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [5*NREQ-1:0]     req_wa,
  input  logic [32*NREQ-1:0]    req_wd,
  output logic                  rf_we,
  output logic [4:0]            rf_wa,
  output logic [31:0]           rf_wd,
  output logic [REQ_IDW-1:0]    rf_gid,
  output logic [16*NREQ-1:0]    stat_grants,
  output logic [15:0]           stat_conflict
);

  // ptr holds the most recently granted index; the search starts just after it.
  logic [REQ_IDW-1:0] ptr;
  logic               sel_any;
  logic [REQ_IDW-1:0] sel_id;
  logic [4:0]         sel_wa;
  logic [31:0]        sel_wd;
  logic [NREQ-1:0]    gnt;

  // Each valid requester's distance from ptr+1 (mod NREQ) is its priority;
  // the smallest distance wins, which is the same as an upward wrapping scan.
  always_comb begin
    int best;
    int d;
    best    = NREQ;
    d       = 0;
    sel_any = 1'b0;
    sel_id  = '0;
    sel_wa  = '0;
    sel_wd  = '0;
    gnt     = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(ptr) - 1;
      if (d < 0) d = d + NREQ;
      if (req_valid[i] && d < best) begin
        best    = d;
        sel_any = 1'b1;
        sel_id  = REQ_IDW'(i);
        sel_wa  = req_wa[5*i +: 5];
        sel_wd  = req_wd[32*i +: 32];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = sel_any && (sel_id == REQ_IDW'(i));
    end
  end

  // No transfer may complete while reset is high.
  assign req_ready = reset ? '0 : gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= REQ_IDW'(NREQ - 1);
      rf_we  <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
      rf_gid <= '0;
    end else if (sel_any) begin
      ptr    <= sel_id;
      rf_wa  <= sel_wa;
      rf_wd  <= sel_wd;
      rf_gid <= sel_id;
      // A write to r0 is accepted and consumes the slot, but is never performed.
      rf_we  <= (sel_wa != 5'd0);
    end else begin
      rf_we  <= 1'b0;
    end
  end

`ifdef WB_STATS_EN
  logic [15:0] gcnt [NREQ];
  logic [15:0] ccnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) gcnt[i] <= '0;
      ccnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && gcnt[i] != 16'hFFFF) gcnt[i] <= gcnt[i] + 16'd1;
      end
      if ($countones(req_valid) > 1 && ccnt != 16'hFFFF) ccnt <= ccnt + 16'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) stat_grants[16*i +: 16] = gcnt[i];
  end
  assign stat_conflict = ccnt;
`else
  assign stat_grants   = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (NREQ=3): directed vector table,
// randomized traffic against a behavioural model, and counter saturation when
// WB_STATS_EN is defined.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic [14:0]   req_wa;
  logic [95:0]   req_wd;
  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;
  logic [1:0]    rf_gid;
  logic [47:0]   stat_grants;
  logic [15:0]   stat_conflict;

  regfile_wb_arbiter #(.NREQ(3), .REQ_IDW(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wa(req_wa), .req_wd(req_wd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_gid(rf_gid), .stat_grants(stat_grants), .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  int          m_ptr = NREQ - 1;
  logic        m_we  = 1'b0;
  logic [4:0]  m_wa  = '0;
  logic [31:0] m_wd  = '0;
  logic [1:0]  m_gid = '0;
  int          m_gr [3] = '{0, 0, 0};
  int          m_conf = 0;
  logic [2:0]  last_gnt = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: check ready mid-cycle, advance the model, check rf_*/stats after the edge.
  task automatic cycle(output logic [2:0] rdy_s);
    int g;
    logic [2:0] er;
    logic [47:0] eg;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (req_valid[j] && g < 0) g = j;
      end
    end
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    rdy_s = req_ready;
    check("req_ready", req_ready, er);
    last_gnt = er;
    if (reset) begin
      m_ptr = NREQ - 1; m_we = 0; m_wa = 0; m_wd = 0; m_gid = 0;
      m_gr = '{0, 0, 0}; m_conf = 0;
    end else begin
      if (g >= 0) begin
        m_ptr = g;
        m_wa  = req_wa[5*g +: 5];
        m_wd  = req_wd[32*g +: 32];
        m_gid = 2'(g);
        m_we  = (m_wa != 0);
        if (m_gr[g] < 65535) m_gr[g]++;
      end else begin
        m_we = 0;
      end
      if ($countones(req_valid) >= 2 && m_conf < 65535) m_conf++;
    end
    @(posedge clk);
    #1;
    check("rf_we", rf_we, m_we);
    check("rf_wa", rf_wa, m_wa);
    check("rf_wd", rf_wd, m_wd);
    check("rf_gid", rf_gid, m_gid);
`ifdef WB_STATS_EN
    eg = {16'(m_gr[2]), 16'(m_gr[1]), 16'(m_gr[0])};
    check("stat_grants", stat_grants, eg);
    check("stat_conflict", stat_conflict, 16'(m_conf));
`else
    eg = '0;
    check("stat_grants", stat_grants, eg);
    check("stat_conflict", stat_conflict, 16'd0);
`endif
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [14:0] wa;
    logic [95:0] wd;
    logic [2:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [2:0] v, input logic [14:0] wa,
                     input logic [95:0] wd, input logic [2:0] e_rdy, input logic e_we,
                     input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [1:0] e_gid);
    vec_t r;
    r.rst = rst; r.v = v; r.wa = wa; r.wd = wd;
    r.e_rdy = e_rdy; r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd; r.e_gid = e_gid;
    tbl.push_back(r);
  endtask

  initial begin
    logic [2:0]  rdy;
    logic [14:0] wa_i;
    logic [95:0] wd_i;
    logic [2:0]  oh [3];
    wa_i = {5'd3, 5'd2, 5'd1};
    wd_i = {32'hC, 32'hB, 32'hA};
    oh[0] = 3'b001; oh[1] = 3'b010; oh[2] = 3'b100;

    // Reset, then idle.
    add(1, 3'b000, '0, '0, 3'b000, 0, 5'd0, 32'h0, 2'd0);
    for (int i = 0; i < 5; i++) add(0, 3'b000, '0, '0, 3'b000, 0, 5'd0, 32'h0, 2'd0);
    // Lone requester 1, back-to-back.
    for (int i = 0; i < 3; i++)
      add(0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
          3'b010, 1, 5'd5, 32'hDEADBEEF, 2'd1);
    // Full contention after reset: 0,1,2,0,1,2.
    add(1, 3'b111, wa_i, wd_i, 3'b000, 0, 5'd0, 32'h0, 2'd0);
    for (int i = 0; i < 6; i++)
      add(0, 3'b111, wa_i, wd_i, oh[i % 3], 1, 5'(i % 3 + 1), 32'hA + 32'(i % 3), 2'(i % 3));
    // Move ptr to 0, then a write to r0 from requester 2 (suppressed but accepted).
    add(0, 3'b001, wa_i, wd_i, 3'b001, 1, 5'd1, 32'hA, 2'd0);
    add(0, 3'b100, {5'd0, 5'd2, 5'd1}, {32'h1234, 32'hB, 32'hA}, 3'b100, 0, 5'd0, 32'h1234, 2'd2);
    // ptr advanced to 2, so 0 wins the 0/2 contention, then 2.
    add(0, 3'b101, {5'd7, 5'd2, 5'd1}, wd_i, 3'b001, 1, 5'd1, 32'hA, 2'd0);
    add(0, 3'b101, {5'd7, 5'd2, 5'd1}, wd_i, 3'b100, 1, 5'd7, 32'hC, 2'd2);
    // Reset mid-stream with 0 and 2 held valid; 0 wins right after.
    add(1, 3'b101, {5'd7, 5'd2, 5'd1}, wd_i, 3'b000, 0, 5'd0, 32'h0, 2'd0);
    add(0, 3'b101, {5'd7, 5'd2, 5'd1}, wd_i, 3'b001, 1, 5'd1, 32'hA, 2'd0);

    reset = 1'b1; req_valid = '0; req_wa = '0; req_wd = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; req_valid = tbl[i].v; req_wa = tbl[i].wa; req_wd = tbl[i].wd;
      cycle(rdy);
      check($sformatf("vec%0d ready", i), rdy, tbl[i].e_rdy);
      check($sformatf("vec%0d we", i), rf_we, tbl[i].e_we);
      check($sformatf("vec%0d wa", i), rf_wa, tbl[i].e_wa);
      check($sformatf("vec%0d wd", i), rf_wd, tbl[i].e_wd);
      check($sformatf("vec%0d gid", i), rf_gid, tbl[i].e_gid);
`ifdef WB_STATS_EN
      if (i == 15) begin
        check("stats conflict x6", stat_conflict, 16'd6);
        check("stats grants 2 each", stat_grants, {16'd2, 16'd2, 16'd2});
      end
`endif
    end

    // Randomized traffic; a waiting requester usually holds its request steady.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !last_gnt[i] && $urandom_range(7) != 0)) begin
          req_valid[i]        = ($urandom_range(9) < 6);
          req_wa[5*i +: 5]    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
          req_wd[32*i +: 32]  = $urandom;
        end
      end
      cycle(rdy);
    end

`ifdef WB_STATS_EN
    // Grant counter saturation with a lone requester.
    reset = 1'b1; req_valid = '0;
    cycle(rdy);
    reset = 1'b0; req_valid = 3'b001; req_wa = {5'd0, 5'd0, 5'd9};
    repeat (70000) @(posedge clk);
    #1;
    check("stat_grants saturate", stat_grants, {16'h0, 16'h0, 16'hFFFF});
    check("stat_conflict lone", stat_conflict, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 register file between NREQ writeback sources, such as the ALU, the load unit and the mul/div unit.
- Round-robin arbitration, valid/ready handshake per requester.
- One registered write per cycle to the register file.
- Sits between the execute/memory writeback stages and the register file write port (we/wa/wd).

Parameters:
NREQ, 3, number of writeback requesters (2..8)
REQ_IDW, 2, width of grant id; must be >= clog2(NREQ)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  requester i has a write pending
req_ready  output  NREQ  requester i granted this cycle (transfer = valid & ready)
req_wa  input  5*NREQ  dest register of requester i, bits [5i+4:5i]
req_wd  input  32*NREQ  write data of requester i, bits [32i+31:32i]
rf_we  output  1  register file write enable
rf_wa  output  5  register file write address
rf_wd  output  32  register file write data
rf_gid  output  REQ_IDW  id of requester that produced the current rf_* write
stat_grants  output  16*NREQ  per-requester grant counters (see Optional Feature)
stat_conflict  output  16  contention cycle counter (see Optional Feature)

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, rf_gid=0, round-robin pointer ptr=NREQ-1, stat counters=0.
- While reset is high, req_ready is all 0.
- Requester rules: requester must hold req_valid and keep wa/wd stable until it sees ready. A requester may drop valid without ready; this is not an error and no write occurs.
- Arbitration: combinational, from req_valid and ptr.
  - Search starts at index (ptr+1) mod NREQ and proceeds upward with wrap.
  - The first valid index gets req_ready, which is one-hot or all zero.
  - At most one grant per cycle. The register file port never stalls, so the arbiter grants whenever any valid is set.
- Pointer update: on a granted cycle, ptr <= granted index at the clock edge. No grant leaves ptr unchanged.
- Latency: 1 cycle. At the grant edge, rf_wa <= req_wa[g], rf_wd <= req_wd[g], rf_gid <= g, and rf_we <= 1 unless req_wa[g]==0.
- No-grant cycle: rf_we <= 0. rf_wa, rf_wd and rf_gid hold their previous values.
- Writes to register 0:
  - Accepted normally: ready asserted and ptr advances.
  - Suppressed: rf_we=0, rf_wa/rf_wd/rf_gid still loaded.
- Fairness: with all NREQ requesters continuously valid, grants follow 0,1,..,NREQ-1,0,... Each requester waits at most NREQ-1 cycles once valid.
- Single requester: a lone valid requester is granted every cycle (back-to-back, full throughput).
- Reset mid-operation:
  - No transfer completes in a cycle with reset high.
  - Outputs go to reset values on that edge.
  - A requester held valid across reset is granted on the first cycle after reset, by priority from ptr=NREQ-1.
- Ordering: writes from the same requester reach rf_* in acceptance order. No cross-requester ordering guarantee beyond round-robin.

Optional Feature:
Macro: WB_STATS_EN
- Defined:
  - stat_grants[16i+15:16i] increments on each accepted transfer of requester i, saturating at 16'hFFFF.
  - stat_conflict increments, saturating, on each cycle with two or more req_valid bits set and reset low.
  - All counters clear on reset.
- Not defined: counter logic is absent and stat_grants/stat_conflict are driven constant 0. The port list is identical in both builds.

Test Plan:
- Reset, then all valid low for 5 cycles -> req_ready=0, rf_we=0, rf_wa=0, rf_wd=0 every cycle.
- Only req 1 valid, wa=5, wd=32'hDEADBEEF, held 3 cycles -> req_ready=3'b010 each cycle; next cycles rf_we=1, rf_wa=5, rf_wd=32'hDEADBEEF, rf_gid=1.
- All 3 valid continuously for 6 cycles after reset, wa=i+1 -> grants 0,1,2,0,1,2; rf_wa sequence 1,2,3,1,2,3 one cycle later. With WB_STATS_EN: stat_conflict=6, each stat_grants field=2.
- Req 2 valid with wa=0, wd=32'h1234 -> req_ready[2]=1, next cycle rf_we=0, rf_gid=2; ptr advanced, so a following req 0/2 contention grants 0.
- Req 0 and 2 valid, reset asserted 1 cycle mid-stream -> req_ready=0 during reset, rf_we=0 after edge; next cycle req 0 granted.
- WB_STATS_EN, req 0 valid 70000 cycles -> stat_grants[15:0] saturates at 16'hFFFF, no wrap.
